// File: rtl/div_unit_ctrl_pkg.sv
// div_unit_ctrl_pkg: constants and types shared by the divide controller,
// its radix-4 core and anything that issues divide ops.
//   div_op_e     - op encoding on req_op
//   div_state_e  - controller state encoding
//   div_ctl_t    - per-operation control latched at acceptance
//   DIV_ALL_ONES / DIV_INT_MIN - special-case result constants
package div_unit_ctrl_pkg;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } div_op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_RESP  = 3'd4
   } div_state_e;

   typedef struct packed {
      div_op_e op;
      logic    neg_q;   // quotient must be negated
      logic    neg_r;   // remainder must be negated
   } div_ctl_t;

   localparam logic [31:0] DIV_ALL_ONES = 32'hFFFF_FFFF;
   localparam logic [31:0] DIV_INT_MIN  = 32'h8000_0000;

   // Bit 0 of the op selects unsigned, bit 1 selects remainder.
   function automatic logic op_is_signed(input div_op_e op);
      return !op[0];
   endfunction

   function automatic logic op_is_rem(input div_op_e op);
      return op[1];
   endfunction

   function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
      return n ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/base4_divider.sv
// base4_divider: unsigned 32/32 radix-4 restoring divider.
// Retires two quotient bits per cycle, so a result appears 17 cycles after
// input_valid: 1 load cycle, then 16 iterations.
//   clk, rst          - clock, synchronous active-high reset
//   input_valid       - load dividend/divisor (ignored while busy)
//   dividend, divisor - unsigned operands
//   output_valid      - one-cycle pulse, quotient/remainder valid
//   quotient, remainder
module base4_divider (
   input  logic        clk,
   input  logic        rst,
   input  logic        input_valid,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        output_valid,
   output logic [31:0] quotient,
   output logic [31:0] remainder
);

   logic [31:0] q_r, r_r, d_r;
   logic [4:0]  cnt;
   logic        busy;

   logic [33:0] shifted, d1, d2, d3;
   logic [1:0]  digit;
   logic [31:0] r_next;

   // Partial remainder is always < divisor, so shifted < 4*divisor fits in
   // 34 bits and the new remainder fits in 32; the subtraction is done
   // modulo 2^32 because the true difference never exceeds that.
   always_comb begin
      shifted = {r_r, q_r[31:30]};
      d1      = {2'b00, d_r};
      d2      = {1'b0, d_r, 1'b0};
      d3      = d1 + d2;
      digit   = 2'd0;
      r_next  = shifted[31:0];
      if (shifted >= d3) begin
         digit  = 2'd3;
         r_next = shifted[31:0] - d3[31:0];
      end else if (shifted >= d2) begin
         digit  = 2'd2;
         r_next = shifted[31:0] - d2[31:0];
      end else if (shifted >= d1) begin
         digit  = 2'd1;
         r_next = shifted[31:0] - d1[31:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         q_r          <= '0;
         r_r          <= '0;
         d_r          <= '0;
         cnt          <= '0;
         busy         <= 1'b0;
         output_valid <= 1'b0;
      end else begin
         output_valid <= 1'b0;
         if (busy) begin
            r_r <= r_next;
            q_r <= {q_r[29:0], digit};
            cnt <= cnt - 5'd1;
            if (cnt == 5'd1) begin
               busy         <= 1'b0;
               output_valid <= 1'b1;
            end
         end else if (input_valid) begin
            q_r  <= dividend;
            r_r  <= '0;
            d_r  <= divisor;
            cnt  <= 5'd16;
            busy <= 1'b1;
         end
      end
   end

   assign quotient  = q_r;
   assign remainder = r_r;

endmodule

// File: rtl/div_unit_ctrl.sv
// div_unit_ctrl: RISC-V style DIV/DIVU/REM/REMU controller around an
// unsigned radix-4 core. Sign handling, divide-by-zero and signed overflow
// are resolved here; only plain unsigned divides reach the core.
//   clk, rst (sync, active low)
//   req_valid/req_ready, req_op, req_rs1, req_rs2, req_tag - request
//   flush      - kill the in-flight operation
//   resp_valid/resp_ready, resp_data, resp_tag            - result
module div_unit_ctrl
   import div_unit_ctrl_pkg::*;
#(
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [31:0]      req_rs1,
   input  logic [31:0]      req_rs2,
   input  logic [TAG_W-1:0] req_tag,
   input  logic             flush,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [31:0]      resp_data,
   output logic [TAG_W-1:0] resp_tag
);

   div_state_e       state;
   div_ctl_t         ctl;
   logic [31:0]      a_mag, b_mag;
   logic [TAG_W-1:0] tag_q;

   logic        core_rst, core_in_valid, core_out_valid;
   logic [31:0] core_quot, core_rem;

   // Request-side decode, used only in the acceptance cycle.
   div_op_e     op_in;
   logic        sgn_in, s1, s2, div0, ovf, special;
   logic [31:0] special_res, core_res;

   assign op_in  = div_op_e'(req_op);
   assign sgn_in = op_is_signed(op_in);
   assign s1     = sgn_in & req_rs1[31];
   assign s2     = sgn_in & req_rs2[31];
   assign div0   = (req_rs2 == 32'd0);
   assign ovf    = sgn_in && (req_rs1 == DIV_INT_MIN) && (req_rs2 == DIV_ALL_ONES);
   assign special = div0 | ovf;

   // Divide-by-zero wins over overflow (rs2 can't be both 0 and -1 anyway).
   assign special_res = div0 ? (op_is_rem(op_in) ? req_rs1 : DIV_ALL_ONES)
                             : (op_is_rem(op_in) ? 32'd0   : DIV_INT_MIN);

   assign core_res = op_is_rem(ctl.op) ? neg_if(ctl.neg_r, core_rem)
                                       : neg_if(ctl.neg_q, core_quot);

   // rst gates ready so nothing is accepted while reset is held.
   assign req_ready     = rst && (state == ST_IDLE) && !flush;
   // A flush in ISSUE must keep the core from ever starting.
   assign core_in_valid = (state == ST_ISSUE) && !flush;
   assign core_rst      = !rst;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_IDLE;
         ctl        <= '0;
         a_mag      <= '0;
         b_mag      <= '0;
         tag_q      <= '0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_tag   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid && !flush) begin
                  ctl.op    <= op_in;
                  ctl.neg_q <= s1 ^ s2;
                  ctl.neg_r <= s1;
                  a_mag     <= neg_if(s1, req_rs1);
                  b_mag     <= neg_if(s2, req_rs2);
                  tag_q     <= req_tag;
                  if (special) begin
                     resp_data  <= special_res;
                     resp_tag   <= req_tag;
                     resp_valid <= 1'b1;
                     state      <= ST_RESP;
                  end else begin
                     state <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: state <= flush ? ST_IDLE : ST_WAIT;
            ST_WAIT: begin
               if (flush) begin
                  // If the core finishes in the flush cycle there is
                  // nothing left to drain.
                  state <= core_out_valid ? ST_IDLE : ST_DRAIN;
               end else if (core_out_valid) begin
                  resp_data  <= core_res;
                  resp_tag   <= tag_q;
                  resp_valid <= 1'b1;
                  state      <= ST_RESP;
               end
            end
            ST_DRAIN: if (core_out_valid) state <= ST_IDLE;
            ST_RESP: begin
               if (flush || resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   base4_divider u_core (
      .clk          (clk),
      .rst          (core_rst),
      .input_valid  (core_in_valid),
      .dividend     (a_mag),
      .divisor      (b_mag),
      .output_valid (core_out_valid),
      .quotient     (core_quot),
      .remainder    (core_rem)
   );

endmodule

// File: tb/tb_div_unit_ctrl.sv
module tb_div_unit_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_rs1, req_rs2;
   logic [4:0]  req_tag;
   logic        flush;
   logic        resp_valid, resp_ready;
   logic [31:0] resp_data;
   logic [4:0]  resp_tag;

   always #5 clk = ~clk;

   div_unit_ctrl #(.TAG_W(5)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
      .flush(flush),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_tag(resp_tag)
   );

   int tests = 0;
   int fails = 0;
   int civ_cnt = 0;
   int resp_cnt = 0;
   int hold_err = 0;
   logic [31:0] last_data;
   logic [4:0]  last_tag;

   // Monitors sample mid-low-phase, after the bench has driven its inputs.
   always @(negedge clk) begin
      #2;
      if (dut.core_in_valid === 1'b1) civ_cnt++;
      if (resp_valid === 1'b1 && resp_ready === 1'b1) begin
         resp_cnt++;
         last_data = resp_data;
         last_tag  = resp_tag;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   // Reference: the architectural divide rules, straight from the ISA.
   function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
      int sa, sb;
      sa = a;
      sb = b;
      if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
         return op[1] ? 32'h0 : 32'h8000_0000;
      if (!op[0]) return op[1] ? 32'(sa % sb) : 32'(sa / sb);
      return op[1] ? (a % b) : (a / b);
   endfunction

   function automatic bit is_special(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
      return (b == 0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   // Offer a request and return at the negedge after it was accepted.
   task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, output bit ok);
      int n;
      n = 0;
      @(negedge clk);
      req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_tag = tag;
      while (!req_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      ok = req_ready;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Full transaction: lat = negedges from acceptance to resp_valid,
   // after_ov = core output_valid was high the cycle before resp_valid.
   task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input int rdy_dly,
                      output logic [31:0] data, output logic [4:0] rtag,
                      output int lat, output bit after_ov, output bit ok);
      bit prev, sent;
      send(op, a, b, tag, sent);
      lat = 1;
      prev = 1'b0;
      while (!resp_valid && lat < 60) begin
         prev = dut.core_out_valid;
         @(negedge clk);
         lat++;
      end
      ok = sent && resp_valid;
      after_ov = prev;
      data = resp_data;
      rtag = resp_tag;
      hold_err = 0;
      for (int i = 0; i < rdy_dly; i++) begin
         @(negedge clk);
         if (resp_data !== data || resp_tag !== rtag || resp_valid !== 1'b1 || req_ready !== 1'b0)
            hold_err++;
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a, b;
      logic [4:0]  tag;
      logic [31:0] exp;
      bit          special;
      int          rdy;
   } vec_t;

   vec_t vecs[$];

   initial begin
      logic [31:0] d;
      logic [4:0]  t;
      int          lat, civ0, r0;
      bit          aov, ok;

      rst = 1'b0; req_valid = 1'b1; req_op = 2'b01; req_rs1 = 32'd5; req_rs2 = 32'd1;
      req_tag = 5'd1; flush = 1'b0; resp_ready = 1'b0;

      vecs.push_back('{2'b00, 32'hFFFF_FFF9, 32'd2,         5'd3,  32'hFFFF_FFFD, 1'b0, 0});
      vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'd2,         5'd4,  32'hFFFF_FFFF, 1'b0, 0});
      vecs.push_back('{2'b01, 32'd100,       32'd0,         5'd5,  32'hFFFF_FFFF, 1'b1, 0});
      vecs.push_back('{2'b11, 32'd100,       32'd0,         5'd6,  32'd100,       1'b1, 0});
      vecs.push_back('{2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8,  32'h8000_0000, 1'b1, 0});
      vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h0000_0000, 1'b1, 0});
      vecs.push_back('{2'b11, 32'd10,        32'd3,         5'd12, 32'd1,         1'b0, 5});
      vecs.push_back('{2'b01, 32'd1000,      32'd7,         5'd10, 32'd142,       1'b0, 0});
      vecs.push_back('{2'b00, 32'd7,         32'hFFFF_FFFE, 5'd13, 32'hFFFF_FFFD, 1'b0, 1});
      vecs.push_back('{2'b10, 32'd7,         32'hFFFF_FFFE, 5'd14, 32'd1,         1'b0, 0});
      vecs.push_back('{2'b10, 32'hFFFF_FFFF, 32'd0,         5'd15, 32'hFFFF_FFFF, 1'b1, 0});
      vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'd1,         5'd31, 32'hFFFF_FFFF, 1'b0, 0});

      // Reset state, with a request already offered.
      repeat (3) @(negedge clk);
      chk("rst_req_ready",  32'(req_ready),  32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_data",  resp_data,       32'd0);
      chk("rst_resp_tag",   32'(resp_tag),   32'd0);
      req_valid = 1'b0;
      rst = 1'b1;
      #1 chk("rst_release_ready", 32'(req_ready), 32'd1);

      // Directed vectors.
      foreach (vecs[i]) begin
         civ0 = civ_cnt;
         run(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag, vecs[i].rdy, d, t, lat, aov, ok);
         chk($sformatf("vec%0d_resp", i), 32'(ok), 32'd1);
         chk($sformatf("vec%0d_data", i), d, vecs[i].exp);
         chk($sformatf("vec%0d_tag", i), 32'(t), 32'(vecs[i].tag));
         if (vecs[i].special) begin
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd1);
            chk($sformatf("vec%0d_core_issues", i), 32'(civ_cnt - civ0), 32'd0);
         end else begin
            chk($sformatf("vec%0d_after_core", i), 32'(aov), 32'd1);
            chk($sformatf("vec%0d_core_issues", i), 32'(civ_cnt - civ0), 32'd1);
         end
         if (vecs[i].rdy > 0) chk($sformatf("vec%0d_hold", i), 32'(hold_err), 32'd0);
      end

      // Flush during WAIT, then a fresh DIVU 20/4 tag 7.
      r0 = resp_cnt;
      send(2'b01, 32'hFFFF_FFF0, 32'd3, 5'd3, ok);
      repeat (3) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1 chk("drain_not_ready", 32'(req_ready), 32'd0);
      run(2'b01, 32'd20, 32'd4, 5'd7, 0, d, t, lat, aov, ok);
      chk("flush_wait_one_resp", 32'(resp_cnt - r0), 32'd1);
      chk("flush_wait_data", last_data, 32'd5);
      chk("flush_wait_tag", 32'(last_tag), 32'd7);

      // Flush during ISSUE: core never started, back to IDLE.
      civ0 = civ_cnt; r0 = resp_cnt;
      send(2'b00, 32'd50, 32'd5, 5'd2, ok);
      flush = 1'b1;
      #1 chk("issue_flush_no_start", 32'(dut.core_in_valid), 32'd0);
      @(negedge clk);
      flush = 1'b0;
      #1 chk("issue_flush_idle", 32'(req_ready), 32'd1);
      resp_ready = 1'b1;
      repeat (25) @(negedge clk);
      resp_ready = 1'b0;
      chk("issue_flush_core_issues", 32'(civ_cnt - civ0), 32'd0);
      chk("issue_flush_no_resp", 32'(resp_cnt - r0), 32'd0);

      // Flush during RESP drops the response.
      send(2'b01, 32'd9, 32'd0, 5'd4, ok);
      chk("resp_flush_pre", 32'(resp_valid), 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("resp_flush_dropped", 32'(resp_valid), 32'd0);
      #1 chk("resp_flush_idle", 32'(req_ready), 32'd1);

      // Reset in the middle of WAIT.
      r0 = resp_cnt;
      send(2'b01, 32'd1000, 32'd3, 5'd11, ok);
      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
      chk("midrst_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_ready_after", 32'(req_ready), 32'd1);
      resp_ready = 1'b1;
      lat = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (resp_valid || dut.core_out_valid) lat++;
      end
      resp_ready = 1'b0;
      chk("midrst_no_output", 32'(lat), 32'd0);
      chk("midrst_no_resp", 32'(resp_cnt - r0), 32'd0);
      run(2'b01, 32'd1000, 32'd3, 5'd11, 0, d, t, lat, aov, ok);
      chk("midrst_recover", d, 32'd333);

      // Randomized operations against the reference model.
      for (int i = 0; i < 40; i++) begin
         logic [1:0]  op;
         logic [31:0] a, b;
         logic [4:0]  tg;
         int          cls;
         op  = 2'($urandom_range(0, 3));
         tg  = 5'($urandom);
         cls = $urandom_range(0, 5);
         case (cls)
            0:       begin a = $urandom; b = 32'd0; end
            1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2:       begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
            default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
         endcase
         run(op, a, b, tg, $urandom_range(0, 2), d, t, lat, aov, ok);
         chk($sformatf("rnd%0d_data op=%0d a=%h b=%h", i, op, a, b), d, model(op, a, b));
         chk($sformatf("rnd%0d_tag", i), 32'(t), 32'(tg));
         if (is_special(op, a, b)) chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'd1);
         else                      chk($sformatf("rnd%0d_after_core", i), 32'(aov), 32'd1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
